dev_tx: RTL and testbench
=========================

DEV_TX -- requirements
Module: dev_tx

Interface
REQ-001 The module SHALL have parameter AW_DEV, default 2, setting the target-device address width.
REQ-002 The module SHALL have parameter DW, default 4, setting the data width.
REQ-003 The module SHALL have parameter DEPTH, default 2, setting the buffer depth to 2**DEPTH entries.
REQ-004 The module SHALL have parameter TMO, default 64, setting the handshake timeout in clk_i cycles.
REQ-005 The module SHALL have port clk_i, input, 1 bit: single clock, with all logic on its rising edge.
REQ-006 The module SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port wr_en_i, input, 1 bit: local write strobe.
REQ-008 The module SHALL have port wr_dat_i, input, DW bits: local write data.
REQ-009 The module SHALL have port wr_adr_i, input, AW_DEV bits: local destination address.
REQ-010 The module SHALL have port wr_full_o, output, 1 bit: buffer full.
REQ-011 The module SHALL have port validtx_o, output, 1 bit: request to the switch port.
REQ-012 The module SHALL have port dat_o, output, DW bits: data to the switch port.
REQ-013 The module SHALL have port adr_o, output, AW_DEV bits: destination address to the switch port.
REQ-014 The module SHALL have port acktx_i, input, 1 bit: acknowledge from the switch port; it is treated as asynchronous to clk_i.
REQ-015 The module SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 The module SHALL have port err_o, output, 1 bit: sticky timeout flag.
REQ-017 The module SHALL have port cnt_o, output, 8 bits: count of completed transfers.

Function
REQ-018 Buffer: the block SHALL implement a FIFO of 2**DEPTH entries, each holding {adr,dat}, with a fill counter DEPTH+1 bits wide.
REQ-019 Write: when wr_en_i=1 and the buffer is not full, the block SHALL store the entry at the rising edge.
REQ-020 Write while full: when wr_en_i=1 and wr_full_o=1, the write SHALL be ignored, even if a pop occurs in the same cycle.
REQ-021 Simultaneous push and pop on a non-full buffer SHALL leave the fill level unchanged.
REQ-022 wr_full_o SHALL be a registered output, high when the fill level equals 2**DEPTH.
REQ-023 acktx_i SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value ack_s.
REQ-024 The FSM SHALL have the states IDLE, REQ and REL.
REQ-025 IDLE: if the buffer is non-empty, the block SHALL pop the head, load dat_o/adr_o, set validtx_o=1 and go to REQ, all at the same edge.
REQ-026 Latency: a write into an empty buffer while in IDLE SHALL cause validtx_o to rise at the next rising edge.
REQ-027 REQ: validtx_o, dat_o and adr_o SHALL be held stable.
REQ-028 REQ: when ack_s=1, the block SHALL clear validtx_o, increment cnt_o and go to REL.
REQ-029 Ack latency: validtx_o SHALL fall at the 3rd rising edge after acktx_i is first sampled high.
REQ-030 Timeout: the block SHALL count cycles in REQ; when the count reaches TMO with ack_s still 0, it SHALL set err_o, clear validtx_o, discard the word without incrementing cnt_o, and go to REL.
REQ-031 REL: validtx_o SHALL be 0; when ack_s=0 the block SHALL go to IDLE; it SHALL never reassert validtx_o while ack_s=1 (4-phase rule).
REQ-032 cnt_o SHALL wrap from 255 to 0.
REQ-033 err_o SHALL remain set until reset.
REQ-034 dat_o and adr_o SHALL retain their last values outside REQ.

Reset
REQ-035 When rst_ni=0 at a rising edge, the block SHALL enter IDLE and empty the buffer.
REQ-036 The same reset SHALL drive validtx_o=0, dat_o=0, adr_o=0, wr_full_o=0, busy_o=0, err_o=0 and cnt_o=0.
REQ-037 The same reset SHALL clear the synchronizer flops and the timeout counter.
REQ-038 A reset asserted mid-REQ SHALL drop validtx_o at that edge; the transfer is abandoned with no completion counted.

Structure
REQ-039 A shared package switch_pkg SHALL hold the FSM state encoding (IDLE/REQ/REL) and the default values of AW_DEV, DW and DEPTH.
REQ-040 The synchronizer SHALL be implemented as the sub-module sync2 (2-flop, 1 bit); the FIFO and FSM SHALL stay inline.

Verification
REQ-041 The bench SHALL write {adr=2,dat=0xA}, then raise acktx_i 3 cycles after validtx_o and drop it 2 cycles after validtx_o falls; required: dat_o=0xA, adr_o=2 stable throughout REQ and cnt_o=1.
REQ-042 The bench SHALL write 5 words back-to-back with DEPTH=2; required: the 5th is dropped (wr_full_o=1), and exactly 4 transfers complete with the first 4 data values in order.
REQ-043 The bench SHALL hold acktx_i=0; required: after TMO=64 cycles in REQ, err_o=1, validtx_o=0, cnt_o=0, and the next buffered word is presented afterwards.
REQ-044 The bench SHALL hold acktx_i=1 after completion; required: validtx_o stays 0 in REL until acktx_i falls, then the next word is presented.
REQ-045 The bench SHALL pull rst_ni low during REQ; required: all outputs return to their reset values at that edge and the buffer is empty.
REQ-046 The bench SHALL complete 256 transfers; required: cnt_o wraps to 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch device ports: FSM state encoding and
// default geometry of the device transmit path.
package switch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2
   } state_t;

   localparam int AW_DEV_DEF = 2;
   localparam int DW_DEF     = 4;
   localparam int DEPTH_DEF  = 2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_r;
   logic sync_r;

   // two-stage capture of the asynchronous input
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d_i;
         sync_r <= meta_r;
      end
   end

   assign q_o = sync_r;

endmodule

// File: rtl/dev_tx.sv
// Device transmit path: buffers local writes and hands them to the switch port
// over a 4-phase valid/ack handshake with timeout.
module dev_tx #(
   parameter int AW_DEV = switch_pkg::AW_DEV_DEF,
   parameter int DW     = switch_pkg::DW_DEF,
   parameter int DEPTH  = switch_pkg::DEPTH_DEF,
   parameter int TMO    = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [DW-1:0]     wr_dat_i,
   input  logic [AW_DEV-1:0] wr_adr_i,
   output logic              wr_full_o,
   output logic              validtx_o,
   output logic [DW-1:0]     dat_o,
   output logic [AW_DEV-1:0] adr_o,
   input  logic              acktx_i,
   output logic              busy_o,
   output logic              err_o,
   output logic [7:0]        cnt_o
);
   import switch_pkg::*;

   localparam int              NENT      = 2**DEPTH;
   localparam int              EW        = AW_DEV + DW;
   localparam int              TW        = $clog2(TMO + 1);
   localparam logic [DEPTH:0]  FILL_FULL = (DEPTH+1)'(NENT);
   localparam logic [DEPTH:0]  FILL_ONE  = (DEPTH+1)'(1);
   localparam logic [DEPTH-1:0] PTR_ONE  = DEPTH'(1);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TMO - 1);

   logic [EW-1:0]     mem_r [NENT];
   logic [DEPTH-1:0]  wr_ptr_r;
   logic [DEPTH-1:0]  rd_ptr_r;
   logic [DEPTH:0]    fill_r;
   logic [DEPTH:0]    fill_nxt_s;
   logic              full_r;
   logic              push_s;
   logic              pop_s;
   logic              ack_s;
   state_t            state_r;
   state_t            state_nxt_s;
   logic [TW-1:0]     tmo_r;
   logic [TW-1:0]     tmo_nxt_s;
   logic              valid_r;
   logic              valid_nxt_s;
   logic [DW-1:0]     dat_r;
   logic [AW_DEV-1:0] adr_r;
   logic              err_r;
   logic              err_nxt_s;
   logic [7:0]        cnt_r;
   logic [7:0]        cnt_nxt_s;
   logic              busy_r;

   sync2 u_ack_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (acktx_i),
      .q_o    (ack_s)
   );

   // a write seen while full is dropped even if the head pops this cycle
   assign push_s = wr_en_i && !full_r;

   // fill level bookkeeping
   always_comb begin
      fill_nxt_s = fill_r;
      if (push_s && !pop_s) begin
         fill_nxt_s = fill_r + FILL_ONE;
      end else if (!push_s && pop_s) begin
         fill_nxt_s = fill_r - FILL_ONE;
      end else begin
         fill_nxt_s = fill_r;
      end
   end

   // storage array, written only on an accepted push
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {wr_adr_i, wr_dat_i};
      end
   end

   // handshake FSM next-state and datapath control
   always_comb begin
      state_nxt_s = state_r;
      valid_nxt_s = valid_r;
      tmo_nxt_s   = tmo_r;
      cnt_nxt_s   = cnt_r;
      err_nxt_s   = err_r;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fill_r != '0) begin
               pop_s       = 1'b1;
               valid_nxt_s = 1'b1;
               tmo_nxt_s   = '0;
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               valid_nxt_s = 1'b0;
               cnt_nxt_s   = cnt_r + 8'd1;
               state_nxt_s = ST_REL;
            end else if (tmo_r == TMO_LAST) begin
               valid_nxt_s = 1'b0;
               err_nxt_s   = 1'b1;
               state_nxt_s = ST_REL;
            end else begin
               tmo_nxt_s   = tmo_r + TW'(1);
            end
         end
         ST_REL: begin
            valid_nxt_s = 1'b0;
            if (!ack_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_REL;
            end
         end
         default: begin
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // all state and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r  <= ST_IDLE;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         fill_r   <= '0;
         full_r   <= 1'b0;
         tmo_r    <= '0;
         valid_r  <= 1'b0;
         dat_r    <= '0;
         adr_r    <= '0;
         err_r    <= 1'b0;
         cnt_r    <= 8'd0;
         busy_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         fill_r  <= fill_nxt_s;
         full_r  <= (fill_nxt_s == FILL_FULL);
         tmo_r   <= tmo_nxt_s;
         valid_r <= valid_nxt_s;
         err_r   <= err_nxt_s;
         cnt_r   <= cnt_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r       <= rd_ptr_r + PTR_ONE;
            {adr_r, dat_r} <= mem_r[rd_ptr_r];
         end
      end
   end

   assign wr_full_o = full_r;
   assign validtx_o = valid_r;
   assign dat_o     = dat_r;
   assign adr_o     = adr_r;
   assign busy_o    = busy_r;
   assign err_o     = err_r;
   assign cnt_o     = cnt_r;

endmodule

// File: tb/tb_dev_tx.sv
// Directed self-checking bench for dev_tx: handshake latency, buffer overflow,
// 4-phase hold, timeout, mid-transfer reset and completion-counter wrap.
module tb_dev_tx;

   localparam int LIMIT = 40;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_dat;
   logic [1:0] wr_adr;
   logic       wr_full;
   logic       validtx;
   logic [3:0] dat;
   logic [1:0] adr;
   logic       acktx;
   logic       busy;
   logic       err;
   logic [7:0] cnt;

   int         n_chk;
   int         n_fail;
   logic [7:0] exp_cnt;

   dev_tx #(.AW_DEV(2), .DW(4), .DEPTH(2), .TMO(64)) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wr_en_i   (wr_en),
      .wr_dat_i  (wr_dat),
      .wr_adr_i  (wr_adr),
      .wr_full_o (wr_full),
      .validtx_o (validtx),
      .dat_o     (dat),
      .adr_o     (adr),
      .acktx_i   (acktx),
      .busy_o    (busy),
      .err_o     (err),
      .cnt_o     (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] d, input logic [1:0] a);
      wr_en  = 1'b1;
      wr_dat = d;
      wr_adr = a;
      tick();
      wr_en  = 1'b0;
   endtask

   task automatic wait_valid(input logic lvl, input string tag);
      for (int i = 0; i < LIMIT && validtx !== lvl; i++) tick();
      chk(tag, validtx, lvl);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < LIMIT && busy !== 1'b0; i++) tick();
      chk("idle", busy, 1'b0);
   endtask

   task automatic xfer(input logic [3:0] d, input logic [1:0] a, input int hold);
      wait_valid(1'b1, "vld_up");
      chk("x_dat", dat, d);
      chk("x_adr", adr, a);
      acktx = 1'b1;
      wait_valid(1'b0, "vld_dn");
      exp_cnt = exp_cnt + 8'd1;
      chk("x_cnt", cnt, exp_cnt);
      repeat (hold) tick();
      acktx = 1'b0;
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      exp_cnt = 8'd0;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_dat  = 4'd0;
      wr_adr  = 2'd0;
      acktx   = 1'b0;
      tick();
      tick();
      chk("rst_valid", validtx, 1'b0);
      chk("rst_full", wr_full, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_cnt", cnt, 8'd0);
      chk("rst_dat", dat, 4'd0);
      rst_n = 1'b1;
      tick();

      // single transfer with exact latencies
      wr(4'hA, 2'd2);
      chk("lat_pre", validtx, 1'b0);
      tick();
      chk("lat_rise", validtx, 1'b1);
      chk("req_dat", dat, 4'hA);
      chk("req_adr", adr, 2'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", validtx, 1'b1);
         chk("hold_dat", dat, 4'hA);
         chk("hold_adr", adr, 2'd2);
      end
      acktx = 1'b1;
      tick();
      chk("ack_e1", validtx, 1'b1);
      tick();
      chk("ack_e2", validtx, 1'b1);
      tick();
      chk("ack_e3", validtx, 1'b0);
      chk("cnt1", cnt, 8'd1);
      chk("rel_busy", busy, 1'b1);
      exp_cnt = 8'd1;
      tick();
      tick();
      acktx = 1'b0;
      wait_idle();
      chk("keep_dat", dat, 4'hA);
      chk("keep_adr", adr, 2'd2);

      // ack held high in REL while the buffer overfills
      wr(4'h3, 2'd1);
      wait_valid(1'b1, "p_up");
      chk("p_dat", dat, 4'h3);
      acktx = 1'b1;
      wait_valid(1'b0, "p_dn");
      exp_cnt = exp_cnt + 8'd1;
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_dat = 4'(i + 1);
         wr_adr = 2'(i);
         tick();
         chk("fill_full", wr_full, (i >= 3) ? 1'b1 : 1'b0);
         chk("rel_hold", validtx, 1'b0);
      end
      wr_en = 1'b0;
      repeat (5) begin
         tick();
         chk("rel_hold2", validtx, 1'b0);
      end
      chk("rel_busy2", busy, 1'b1);
      acktx = 1'b0;
      for (int i = 0; i < 4; i++) xfer(4'(i + 1), 2'(i), 2);
      repeat (10) tick();
      chk("drop5", validtx, 1'b0);
      chk("empty_full", wr_full, 1'b0);
      chk("cnt6", cnt, 8'd6);

      // reset in the middle of REQ with words still buffered
      wr(4'h9, 2'd2);
      wr(4'hB, 2'd3);
      wr(4'hC, 2'd0);
      wait_valid(1'b1, "r_up");
      rst_n = 1'b0;
      tick();
      chk("mr_valid", validtx, 1'b0);
      chk("mr_dat", dat, 4'd0);
      chk("mr_adr", adr, 2'd0);
      chk("mr_full", wr_full, 1'b0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_err", err, 1'b0);
      chk("mr_cnt", cnt, 8'd0);
      rst_n   = 1'b1;
      exp_cnt = 8'd0;
      repeat (8) tick();
      chk("mr_empty", validtx, 1'b0);
      chk("mr_idle", busy, 1'b0);

      // timeout with ack held low
      wr(4'h7, 2'd1);
      wr(4'h8, 2'd3);
      wait_valid(1'b1, "t_up");
      chk("t_dat", dat, 4'h7);
      repeat (63) tick();
      chk("t_pre", validtx, 1'b1);
      tick();
      chk("t_valid", validtx, 1'b0);
      chk("t_err", err, 1'b1);
      chk("t_cnt", cnt, 8'd0);
      xfer(4'h8, 2'd3, 1);
      chk("t_sticky", err, 1'b1);

      // counter wrap
      for (int k = 0; k < 255; k++) begin
         wr(4'(k), 2'(k));
         xfer(4'(k), 2'(k), 0);
      end
      chk("wrap", cnt, 8'd0);
      chk("wrap_err", err, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
